regfile_wr_arbiter: RTL

Write-port controller for the three-ported 32×32 register file in the multicycle CPU. It shares the file's single write port between the core writeback path and a debug/loader port, using core-priority arbitration with a starvation guard. After reset, and on request, it zero-initialises registers 1..31 by sequencing writes through the same port. Its registered outputs drive the register file's WE3/A3/WD3 directly.

---
 rtl/regfile_ctrl_pkg.sv | 17 +
 rtl/regfile_wr_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default widths for the register-file write-port controller.
package regfile_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between core writeback and a debug port,
// and zero-initialises x1..x(N-1) after reset or on clear_req.
module regfile_wr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic              clear_req,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int                  STARVE_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0]   FIRST_ADDR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR  = '1;

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   clr_cnt_q,  clr_cnt_d;
  logic [STARVE_W-1:0] starve_q,   starve_d;
  logic                rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                force_dbg;

  assign force_dbg = (starve_q == STARVE_MAX);

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // one unassigned; that is what keeps this combinational block latch-free.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    core_ready = 1'b0;
    dbg_ready  = 1'b0;

    unique case (state_q)
      CLEAR: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = clr_cnt_q;
        rf_wdata_d = '0;
        starve_d   = '0;
        if (clear_req) begin
          clr_cnt_d = FIRST_ADDR;
        end else if (clr_cnt_q == LAST_ADDR) begin
          state_d = ARB;
        end else begin
          clr_cnt_d = clr_cnt_q + FIRST_ADDR;
        end
      end

      ARB: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = FIRST_ADDR;
          starve_d  = '0;
        end else begin
          core_ready = !force_dbg;
          dbg_ready  = force_dbg || !core_valid;
          // The ready terms are mutually exclusive whenever core_valid is high.
          if (core_valid && core_ready) begin
            rf_we_d    = (core_addr != '0);
            rf_waddr_d = core_addr;
            rf_wdata_d = core_data;
          end else if (dbg_valid && dbg_ready) begin
            rf_we_d    = (dbg_addr != '0);
            rf_waddr_d = dbg_addr;
            rf_wdata_d = dbg_data;
          end
          if (dbg_valid && !dbg_ready) begin
            starve_d = force_dbg ? starve_q : starve_q + STARVE_W'(1);
          end else begin
            starve_d = '0;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= FIRST_ADDR;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
